// File: rtl/sprinkler_cycle_controller.sv
// Sprinkler irrigation cycle FSM: loads a BCD preset, counts it down on ticks while the
// valve is open, pauses on low water, then rests for a fixed number of ticks.
module sprinkler_cycle_controller #(
  parameter logic [3:0]  PRESET_TENS  = 4'd1,
  parameter logic [3:0]  PRESET_UNITS = 4'd5,
  parameter int unsigned REST_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_req,
  input  logic       abort,
  input  logic       water_low,
  output logic       valve_on,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StHold, StRest} state_e;

  localparam logic [3:0] RestLast = 4'(REST_TICKS - 1);

  state_e     state;
  logic [3:0] rest_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      valve_on <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tens     <= 4'd0;
      units    <= 4'd0;
      rest_cnt <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_req && !water_low && !abort) begin
            state <= StLoad;
            tens  <= PRESET_TENS;
            units <= PRESET_UNITS;
            busy  <= 1'b1;
          end
        end
        StLoad: begin
          if (abort) begin
            state <= StIdle;
            tens  <= 4'd0;
            units <= 4'd0;
            busy  <= 1'b0;
          end else begin
            state    <= StRun;
            valve_on <= 1'b1;
          end
        end
        StRun: begin
          // Priority: abort, then water_low, then tick.
          if (abort) begin
            state    <= StIdle;
            tens     <= 4'd0;
            units    <= 4'd0;
            busy     <= 1'b0;
            valve_on <= 1'b0;
          end else if (water_low) begin
            state    <= StHold;
            valve_on <= 1'b0;
          end else if (tick) begin
            if (tens == 4'd0 && units <= 4'd1) begin
              // Last second, or a preset of 00 which finishes on its first tick.
              state    <= StRest;
              units    <= 4'd0;
              done     <= 1'b1;
              valve_on <= 1'b0;
              rest_cnt <= 4'd0;
            end else if (units != 4'd0) begin
              units <= units - 4'd1;
            end else begin
              units <= 4'd9;
              tens  <= tens - 4'd1;
            end
          end
        end
        StHold: begin
          if (abort) begin
            state <= StIdle;
            tens  <= 4'd0;
            units <= 4'd0;
            busy  <= 1'b0;
          end else if (!water_low) begin
            state    <= StRun;
            valve_on <= 1'b1;
          end
        end
        StRest: begin
          if (tick) begin
            if (rest_cnt == RestLast) begin
              state    <= StIdle;
              busy     <= 1'b0;
              rest_cnt <= 4'd0;
            end else begin
              rest_cnt <= rest_cnt + 4'd1;
            end
          end
        end
        default: begin
          state    <= StIdle;
          valve_on <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprinkler_cycle_controller.sv
// Directed bench for the sprinkler cycle controller: default preset plus a 00-preset instance.
module tb_sprinkler_cycle_controller;

  logic       clk = 1'b0;
  logic       rst_n, tick, start_req, abort, water_low;
  logic       valve_on, busy, done;
  logic [3:0] tens, units;
  logic       valve0, busy0, done0;
  logic [3:0] tens0, units0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprinkler_cycle_controller u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start_req (start_req),
    .abort     (abort),
    .water_low (water_low),
    .valve_on  (valve_on),
    .tens      (tens),
    .units     (units),
    .busy      (busy),
    .done      (done)
  );

  sprinkler_cycle_controller #(
    .PRESET_TENS  (4'd0),
    .PRESET_UNITS (4'd0),
    .REST_TICKS   (3)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start_req (start_req),
    .abort     (abort),
    .water_low (water_low),
    .valve_on  (valve0),
    .tens      (tens0),
    .units     (units0),
    .busy      (busy0),
    .done      (done0)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with tick driven to t; returns 1 time unit after the rising edge.
  task automatic step(input logic t);
    @(negedge clk);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_req = 1'b0; abort = 1'b0; water_low = 1'b0;
    #12;
    check("rst_valve", {7'd0, valve_on}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_digits", {tens, units}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    check("idle_after_rst", {7'd0, busy}, 8'd0);

    // water_low inhibits a start from IDLE
    start_req = 1'b1; water_low = 1'b1;
    step(1'b0);
    check("idle_inhibit", {7'd0, busy}, 8'd0);
    water_low = 1'b0;

    // Full default cycle: 15 seconds
    step(1'b0);
    start_req = 1'b0;
    check("load_busy", {7'd0, busy}, 8'd1);
    check("load_digits", {tens, units}, 8'h15);
    check("load_valve", {7'd0, valve_on}, 8'd0);
    step(1'b0);
    check("run_valve", {7'd0, valve_on}, 8'd1);
    step(1'b0);
    check("run_notick", {tens, units}, 8'h15);
    for (int i = 1; i <= 15; i++) begin
      step(1'b1);
      check("cnt_digits", {tens, units}, bcd(15 - i));
      check("cnt_done", {7'd0, done}, {7'd0, (i == 15)});
      check("cnt_valve", {7'd0, valve_on}, {7'd0, (i != 15)});
    end
    step(1'b0);
    check("done_pulse_end", {7'd0, done}, 8'd0);
    abort = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      check("rest_busy", {7'd0, busy}, {7'd0, (i != 3)});
      check("rest_valve", {7'd0, valve_on}, 8'd0);
    end
    abort = 1'b0;

    // Hold on water_low, resume from 09
    start_req = 1'b1;
    step(1'b0);
    start_req = 1'b0;
    step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    check("pre_hold", {tens, units}, 8'h09);
    water_low = 1'b1;
    step(1'b0);
    check("hold_valve", {7'd0, valve_on}, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b1);
    check("hold_digits", {tens, units}, 8'h09);
    check("hold_busy", {7'd0, busy}, 8'd1);
    water_low = 1'b0;
    step(1'b0);
    check("resume_valve", {7'd0, valve_on}, 8'd1);
    step(1'b1);
    check("resume_cnt", {tens, units}, 8'h08);

    // water_low beats a simultaneous tick
    water_low = 1'b1;
    step(1'b1);
    check("wl_tick_digits", {tens, units}, 8'h08);
    check("wl_tick_valve", {7'd0, valve_on}, 8'd0);
    water_low = 1'b0;
    step(1'b0);
    step(1'b1);
    check("pre_abort", {tens, units}, 8'h07);

    // Abort at 07, with a tick that would otherwise count
    abort = 1'b1;
    step(1'b1);
    abort = 1'b0;
    check("abort_digits", {tens, units}, 8'h00);
    check("abort_valve", {7'd0, valve_on}, 8'd0);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_done", {7'd0, done}, 8'd0);

    // Asynchronous reset mid-RUN at 12
    start_req = 1'b1;
    step(1'b0);
    start_req = 1'b0;
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("pre_rst", {tens, units}, 8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valve", {7'd0, valve_on}, 8'd0);
    check("async_digits", {tens, units}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    step(1'b0);
    check("post_rst_idle", {7'd0, busy}, 8'd0);

    // Preset 00 with start_req held: back-to-back cycles
    start_req = 1'b1;
    step(1'b0);
    check("p00_load", {7'd0, busy0}, 8'd1);
    check("p00_load_digits", {tens0, units0}, 8'h00);
    step(1'b0);
    check("p00_run_valve", {7'd0, valve0}, 8'd1);
    step(1'b1);
    check("p00_done", {7'd0, done0}, 8'd1);
    check("p00_digits", {tens0, units0}, 8'h00);
    check("p00_valve_off", {7'd0, valve0}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      check("p00_rest", {7'd0, busy0}, {7'd0, (i != 3)});
    end
    step(1'b0);
    check("p00_restart", {7'd0, busy0}, 8'd1);
    step(1'b0);
    check("p00_rerun", {7'd0, valve0}, 8'd1);
    start_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprinkler_cycle_controller.md
SPRINKLER_CYCLE_CONTROLLER -- requirements
Module: sprinkler_cycle_controller

Interface
REQ-001 Parameter PRESET_TENS, default 4'd1: tens BCD digit loaded at cycle start, legal range 0-9.
REQ-002 Parameter PRESET_UNITS, default 4'd5: units BCD digit loaded at cycle start, legal range 0-9.
REQ-003 Parameter REST_TICKS, default 3: number of ticks spent in REST before a new cycle is accepted, legal range 1-15.
REQ-004 Port clk, input, 1: single system clock; all state changes occur on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port tick, input, 1: one-clk-wide time-base strobe, one per countdown second.
REQ-007 Port start_req, input, 1: irrigation request from the soil-moisture logic, level-sensitive.
REQ-008 Port abort, input, 1: manual stop request.
REQ-009 Port water_low, input, 1: tank-empty inhibit.
REQ-010 Port valve_on, output, 1: sprinkler valve drive.
REQ-011 Port tens, output, 4: BCD tens digit of the remaining time.
REQ-012 Port units, output, 4: BCD units digit of the remaining time.
REQ-013 Port busy, output, 1: high in the LOAD, RUN, HOLD and REST states.
REQ-014 Port done, output, 1: one-clk pulse when a RUN completes normally.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, RUN, HOLD and REST, encoded in registered state.
REQ-016 IDLE: start_req=1 and water_low=0 and abort=0 SHALL move to LOAD on the next edge; all other input combinations SHALL stay in IDLE.
REQ-017 LOAD SHALL last exactly one clk, SHALL load tens=PRESET_TENS and units=PRESET_UNITS, and SHALL then go to RUN.
REQ-018 valve_on SHALL be 1 only in RUN; valve_on is a registered output that rises on the same edge the state enters RUN.
REQ-019 RUN, on tick=1 with units!=0: units SHALL decrement by 1.
REQ-020 RUN, on tick=1 with units=0 and tens!=0: units SHALL become 9 and tens SHALL decrement by 1 (BCD borrow).
REQ-021 RUN, on tick=1 with tens=0 and units=1: units SHALL become 0, done SHALL pulse on the same edge, and the state SHALL go to REST.
REQ-022 A preset of 00 SHALL complete on the first tick in RUN, with done=1 and next state REST.
REQ-023 RUN with water_low=1 SHALL go to HOLD on the next edge, and the digits SHALL freeze; water_low takes priority over a simultaneous tick.
REQ-024 HOLD: the digits SHALL be frozen and ticks ignored; water_low=0 SHALL return the state to RUN on the next edge.
REQ-025 abort=1 in LOAD, RUN or HOLD SHALL go to IDLE on the next edge, SHALL clear the digits to 00, and SHALL suppress done; abort has the highest priority.
REQ-026 REST SHALL count REST_TICKS ticks with valve_on=0 and then go to IDLE; abort SHALL be ignored in REST.
REQ-027 start_req held high through REST SHALL start a new cycle on the first clk in IDLE, i.e. there is no edge detection on start_req.
REQ-028 The digits SHALL never hold non-BCD values (A-F) and SHALL never wrap below 00.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, valve_on=0, busy=0, done=0, tens=0, units=0, rest counter=0.
REQ-030 Deassertion of rst_n SHALL take effect on the following clk edge, and the first state change SHALL occur no earlier than that edge.
REQ-031 Reset asserted mid-RUN SHALL drop valve_on asynchronously, before the next clk edge.

Verification
REQ-032 Defaults, start_req pulse, 15 ticks -> LOAD 15; digits 14, 13, ..., 10, 09, ..., 01, 00; done on the 15th tick; valve_on high for 15 ticks; 3 ticks of REST, then IDLE.
REQ-033 RUN at 10, then tick -> 09; apply water_low=1 for 5 ticks -> HOLD, digits stay 09, valve_on=0; release water_low -> RUN resumes from 09.
REQ-034 water_low=1 and tick asserted on the same edge in RUN -> HOLD, digits unchanged.
REQ-035 abort at digits 07 -> IDLE, digits 00, no done pulse, valve_on=0 on the next edge.
REQ-036 rst_n low at digits 12 in RUN -> valve_on=0 and digits 00 immediately; after release, IDLE until start_req.
REQ-037 PRESET 00 -> LOAD, RUN, then done on the first tick with zero further decrements; also start_req held high continuously -> back-to-back cycles separated by exactly REST_TICKS ticks plus one IDLE clk.
